// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encodings and clock-derived cycle constants
// used by the debouncer and the pulse stretcher.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  localparam int unsigned CLK_HZ = 100000000;
  localparam int unsigned MS_250 = CLK_HZ / 4;
  localparam int unsigned MS_500 = CLK_HZ / 2;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse when d goes high; a level already high
// on the first cycle after reset counts as a rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HOLD_CYCLES-long levels, queueing events that
// arrive mid-output and replaying them with a GAP_CYCLES low gap between.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no output in progress, waiting for an event
// ST_HOLD | stretched high, timer counting HOLD_CYCLES
// ST_GAP  | stretched forced low, timer counting GAP_CYCLES
module pulse_stretcher
  import pong_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = MS_250,
  parameter int unsigned GAP_CYCLES  = MS_250,
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse,
  output logic              stretched,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             ev;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (pulse),
    .rise (ev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      stretched <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev) begin
            state     <= ST_HOLD;
            timer     <= '0;
            stretched <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (timer == HOLD_LAST) begin
            state     <= ST_GAP;
            timer     <= '0;
            stretched <= 1'b0;
          end else begin
            timer <= timer + CNT_ONE;
          end
          if (ev) begin
            if (pending == PEND_MAX) overflow <= 1'b1;
            else                     pending  <= pending + PEND_ONE;
          end
        end

        ST_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            // A same-cycle event replaces the queued one being started, so no drop here.
            if (pending != '0) begin
              state     <= ST_HOLD;
              stretched <= 1'b1;
              if (!ev) pending <= pending - PEND_ONE;
            end else if (ev) begin
              state     <= ST_HOLD;
              stretched <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + CNT_ONE;
            if (ev) begin
              if (pending == PEND_MAX) overflow <= 1'b1;
              else                     pending  <= pending + PEND_ONE;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          timer     <= '0;
          stretched <= 1'b0;
          busy      <= 1'b0;
          pending   <= '0;
          overflow  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: vector table, hand-built corner sequences and a
// random run against a schedule-based reference model.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int MP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse;
  logic       stretched;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PENDING (MP),
    .CNT_W       (3),
    .PEND_W      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse     (pulse),
    .stretched (stretched),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       r;
    logic       p;
    logic       s;
    logic       b;
    logic [1:0] pd;
    logic       o;
  } vec_t;
  vec_t tbl[$];

  // Reference model: each accepted event owns a start edge; a period occupies
  // H high cycles then G low cycles, and starts are spaced at least H+G apart.
  int starts[$];
  bit m_ovf;
  bit m_pq;
  int t = 0;

  logic s_log[64];
  logic b_log[64];
  logic [1:0] p_log[64];
  logic o_log[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  function automatic int cnt_after(input int tt);
    int c = 0;
    foreach (starts[i]) if (starts[i] > tt) c++;
    return c;
  endfunction

  function automatic bit m_str();
    foreach (starts[i]) if (starts[i] <= t && t < starts[i] + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    foreach (starts[i]) if (starts[i] <= t && t < starts[i] + H + G) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic p);
    bit ev;
    int st;
    rst   = r;
    pulse = p;
    @(posedge clk);
    #1;
    t++;
    if (r) begin
      starts.delete();
      m_ovf = 1'b0;
      m_pq  = 1'b0;
    end else begin
      ev   = p & ~m_pq;
      m_pq = p;
      while (starts.size() > 0 && starts[0] + H + G <= t) void'(starts.pop_front());
      if (ev) begin
        if (cnt_after(t) >= MP) m_ovf = 1'b1;
        else begin
          st = t;
          if (starts.size() > 0 && starts[$] + H + G > st) st = starts[$] + H + G;
          starts.push_back(st);
        end
      end
    end
  endtask

  task automatic add(input logic r, input logic p, input logic s, input logic b,
                     input logic [1:0] pd, input logic o, input int n);
    vec_t v;
    v.r = r; v.p = p; v.s = s; v.b = b; v.pd = pd; v.o = o;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic run_pat(input logic [63:0] pat, input int len, input int rst_off);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int off = 0; off < len; off++) begin
      step(off == rst_off, pat[off]);
      s_log[off] = stretched;
      b_log[off] = busy;
      p_log[off] = pending;
      o_log[off] = overflow;
    end
  endtask

  function automatic int highs(input int from, input int len);
    int h = 0;
    for (int i = from; i < len; i++) if (s_log[i] === 1'b1) h++;
    return h;
  endfunction

  initial begin
    rst   = 1'b1;
    pulse = 1'b0;

    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 4);
    add(0, 1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 14);
    add(0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].p);
      chk("tbl_stretched", stretched, tbl[i].s);
      chk("tbl_busy",      busy,      tbl[i].b);
      chk("tbl_pending",   pending,   tbl[i].pd);
      chk("tbl_overflow",  overflow,  tbl[i].o);
    end

    // Four queued events replayed back to back.
    run_pat(64'h155, 40, -1);
    chk("seqA_pend9",  p_log[9],  3);
    chk("seqA_pend12", p_log[12], 2);
    chk("seqA_pend18", p_log[18], 1);
    chk("seqA_pend24", p_log[24], 0);
    chk("seqA_gap5",   s_log[5],  0);
    chk("seqA_hold6",  s_log[6],  1);
    chk("seqA_busy29", b_log[29], 1);
    chk("seqA_busy30", b_log[30], 0);
    chk("seqA_highs",  highs(0, 40), 20);
    chk("seqA_ovf",    o_log[39], 0);

    // Saturation: one event dropped, overflow sticky until rst.
    run_pat(64'h555, 40, -1);
    chk("seqB_ovf9",   o_log[9],  0);
    chk("seqB_ovf10",  o_log[10], 1);
    chk("seqB_pend10", p_log[10], 3);
    chk("seqB_ovf39",  o_log[39], 1);
    chk("seqB_highs",  highs(0, 40), 20);
    step(1'b1, 1'b0);
    chk("seqB_ovf_rst", overflow, 0);

    // Event on the last GAP cycle with nothing pending.
    run_pat(64'h41, 16, -1);
    chk("seqC_gap5",   s_log[5],  0);
    chk("seqC_busy5",  b_log[5],  1);
    chk("seqC_hold6",  s_log[6],  1);
    chk("seqC_pend6",  p_log[6],  0);
    chk("seqC_busy11", b_log[11], 1);
    chk("seqC_busy12", b_log[12], 0);
    chk("seqC_highs",  highs(0, 16), 8);

    // Event on the last GAP cycle with one pending.
    run_pat(64'h45, 24, -1);
    chk("seqC2_pend2",  p_log[2],  1);
    chk("seqC2_pend6",  p_log[6],  1);
    chk("seqC2_hold6",  s_log[6],  1);
    chk("seqC2_pend12", p_log[12], 0);
    chk("seqC2_hold12", s_log[12], 1);
    chk("seqC2_highs",  highs(0, 24), 12);

    // rst with events queued: everything cleared, no replays.
    run_pat(64'h35, 20, 5);
    chk("seqD_pend4",  p_log[4], 2);
    chk("seqD_str5",   s_log[5], 0);
    chk("seqD_busy5",  b_log[5], 0);
    chk("seqD_pend5",  p_log[5], 0);
    chk("seqD_highs",  highs(6, 20), 0);
    chk("seqD_busy19", b_log[19], 0);

    // Random traffic against the model.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0);
      chk("rnd_stretched", stretched, m_str());
      chk("rnd_busy",      busy,      m_busy());
      chk("rnd_pending",   pending,   cnt_after(t));
      chk("rnd_overflow",  overflow,  m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
